// File: rtl/stage_sequencer.sv
// Micro-step sequencer for the 8-bit CPU control decoder: trims each instruction
// to its opcode length, freezes on halt, and supports free-run and single-step modes.
module stage_sequencer #(
  parameter int MAX_STAGE    = 4,
  parameter bit FIXED_LENGTH = 1'b0,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       ir,
  input  logic             ctrl_ht,
  input  logic             run_mode,
  input  logic             step_req,
  input  logic             resume,
  output logic [2:0]       stage,
  output logic             halted,
  output logic             instr_done,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_WAIT = 2'd1,
    S_HALT = 2'd2
  } state_e;

  state_e           state_q;
  logic [2:0]       stage_q;
  logic             halted_q;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;
  logic             s1_q, s2_q, s3_q;

  logic [2:0] last_stage;
  logic       step_pulse;
  logic       advance;
  logic       unused_ir;

  assign unused_ir = ^ir[3:0];

  // Last stage is always >= 2, so fetch stages 0/1 can never retire and ir is
  // irrelevant there.
  always_comb begin
    last_stage = 3'd2;
    if (FIXED_LENGTH) begin
      last_stage = 3'(MAX_STAGE);
    end else begin
      case (ir[7:4])
        4'h1, 4'h4: last_stage = 3'd3;
        4'h2, 4'h3: last_stage = 3'd4;
        default:    last_stage = 3'd2;
      endcase
    end
  end

  assign step_pulse = s2_q & ~s3_q;
  assign advance    = (state_q == S_RUN) || ((state_q == S_WAIT) && step_pulse);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= run_mode ? S_RUN : S_WAIT;
      stage_q  <= 3'd0;
      halted_q <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      s1_q     <= 1'b0;
      s2_q     <= 1'b0;
      s3_q     <= 1'b0;
    end else begin
      s1_q   <= step_req;
      s2_q   <= s1_q;
      s3_q   <= s2_q;
      done_q <= 1'b0;
      case (state_q)
        S_HALT: begin
          // The HLT instruction itself retires on resume.
          if (resume) begin
            state_q  <= run_mode ? S_RUN : S_WAIT;
            halted_q <= 1'b0;
            stage_q  <= 3'd0;
            done_q   <= 1'b1;
            cnt_q    <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          if (ctrl_ht) begin
            state_q  <= S_HALT;
            halted_q <= 1'b1;
          end else begin
            state_q <= run_mode ? S_RUN : S_WAIT;
            if (advance) begin
              if (stage_q == last_stage) begin
                stage_q <= 3'd0;
                done_q  <= 1'b1;
                cnt_q   <= cnt_q + CNT_W'(1);
              end else begin
                stage_q <= stage_q + 3'd1;
              end
            end
          end
        end
      endcase
    end
  end

  assign stage       = stage_q;
  assign halted      = halted_q;
  assign instr_done  = done_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer: per-opcode length instance plus a
// fixed-length instance with a narrow counter for the wrap check.
module tb_stage_sequencer;

  logic        clk;
  logic        rst_n;
  logic [7:0]  ir;
  logic        ctrl_ht;
  logic        run_mode;
  logic        step_req;
  logic        resume;
  logic [2:0]  stage;
  logic        halted;
  logic        instr_done;
  logic [15:0] instr_count;
  logic [2:0]  fx_stage;
  logic        fx_halted;
  logic        fx_done;
  logic [3:0]  fx_count;

  int checks = 0;
  int errors = 0;

  stage_sequencer dut (
    .clk(clk), .rst_n(rst_n), .ir(ir), .ctrl_ht(ctrl_ht), .run_mode(run_mode),
    .step_req(step_req), .resume(resume), .stage(stage), .halted(halted),
    .instr_done(instr_done), .instr_count(instr_count)
  );

  stage_sequencer #(.MAX_STAGE(4), .FIXED_LENGTH(1'b1), .CNT_W(4)) dut_fx (
    .clk(clk), .rst_n(rst_n), .ir(ir), .ctrl_ht(ctrl_ht), .run_mode(run_mode),
    .step_req(step_req), .resume(resume), .stage(fx_stage), .halted(fx_halted),
    .instr_done(fx_done), .instr_count(fx_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic mode);
    ir       = 8'h00;
    ctrl_ht  = 1'b0;
    resume   = 1'b0;
    step_req = 1'b0;
    run_mode = mode;
    rst_n    = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    ir = 8'h00; ctrl_ht = 1'b0; resume = 1'b0; step_req = 1'b0; run_mode = 1'b1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stage !== 3'd0 || halted !== 1'b0 || instr_done !== 1'b0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL reset_values stage=%0d halted=%b done=%b count=%0d expected 0/0/0/0",
               stage, halted, instr_done, instr_count);
    end
    tick();
    tick();
    checks++;
    if (stage !== 3'd0 || fx_stage !== 3'd0 || fx_count !== 4'd0) begin
      errors++;
      $display("FAIL reset_held stage=%0d fx_stage=%0d fx_count=%0d expected 0/0/0",
               stage, fx_stage, fx_count);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_run_add();
    int exp_st[6] = '{1, 2, 3, 4, 0, 1};
    do_reset(1'b1);
    ir = 8'h2A;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (stage !== 3'(exp_st[i]) || instr_done !== (i == 4)) begin
        errors++;
        $display("FAIL run_add edge%0d stage=%0d done=%b expected %0d/%b",
                 i, stage, instr_done, exp_st[i], (i == 4));
      end
    end
    checks++;
    if (instr_count !== 16'd1) begin
      errors++;
      $display("FAIL run_add_count got=%0d expected 1", instr_count);
    end
  endtask

  task automatic test_ldi_lda();
    int exp_st[7] = '{1, 2, 0, 1, 2, 3, 0};
    do_reset(1'b1);
    ir = 8'h57;
    for (int i = 0; i < 7; i++) begin
      tick();
      if (i == 2) ir = 8'h14;
      checks++;
      if (stage !== 3'(exp_st[i])) begin
        errors++;
        $display("FAIL ldi_lda edge%0d stage=%0d expected %0d", i, stage, exp_st[i]);
      end
    end
    checks++;
    if (instr_count !== 16'd2) begin
      errors++;
      $display("FAIL ldi_lda_count got=%0d expected 2", instr_count);
    end
  endtask

  task automatic test_fixed();
    int exp_fx[5] = '{1, 2, 3, 4, 0};
    int exp_vr[5] = '{1, 2, 0, 1, 2};
    do_reset(1'b1);
    ir = 8'h57;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (fx_stage !== 3'(exp_fx[i]) || stage !== 3'(exp_vr[i])) begin
        errors++;
        $display("FAIL fixed_ldi edge%0d fx_stage=%0d stage=%0d expected %0d/%0d",
                 i, fx_stage, stage, exp_fx[i], exp_vr[i]);
      end
    end
    ir = 8'h14;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (fx_stage !== 3'(exp_fx[i]) || fx_done !== (i == 4)) begin
        errors++;
        $display("FAIL fixed_lda edge%0d fx_stage=%0d done=%b expected %0d/%b",
                 i, fx_stage, fx_done, exp_fx[i], (i == 4));
      end
    end
    checks++;
    if (fx_count !== 4'd2) begin
      errors++;
      $display("FAIL fixed_count got=%0d expected 2", fx_count);
    end
  endtask

  task automatic test_halt();
    do_reset(1'b1);
    ir = 8'hF0;
    tick();
    resume = 1'b1;
    tick();
    resume = 1'b0;
    checks++;
    if (stage !== 3'd2 || instr_done !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL resume_ignored stage=%0d done=%b halted=%b expected 2/0/0",
               stage, instr_done, halted);
    end
    ctrl_ht = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (stage !== 3'd2 || halted !== 1'b1 || instr_done !== 1'b0) begin
        errors++;
        $display("FAIL halt_frozen cyc%0d stage=%0d halted=%b done=%b expected 2/1/0",
                 i, stage, halted, instr_done);
      end
    end
    resume = 1'b1;
    tick();
    resume  = 1'b0;
    ctrl_ht = 1'b0;
    ir      = 8'h00;
    checks++;
    if (stage !== 3'd0 || halted !== 1'b0 || instr_done !== 1'b1 || instr_count !== 16'd1) begin
      errors++;
      $display("FAIL halt_resume stage=%0d halted=%b done=%b count=%0d expected 0/0/1/1",
               stage, halted, instr_done, instr_count);
    end
    tick();
    checks++;
    if (stage !== 3'd1 || instr_done !== 1'b0 || halted !== 1'b0) begin
      errors++;
      $display("FAIL after_resume stage=%0d done=%b halted=%b expected 1/0/0",
               stage, instr_done, halted);
    end
  endtask

  task automatic test_step();
    do_reset(1'b0);
    ir = 8'h14;
    step_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (stage !== ((i >= 2) ? 3'd1 : 3'd0)) begin
        errors++;
        $display("FAIL step_hold edge%0d stage=%0d expected %0d", i, stage, (i >= 2) ? 1 : 0);
      end
    end
    step_req = 1'b0;
    tick(); tick(); tick();
    for (int p = 0; p < 2; p++) begin
      step_req = 1'b1;
      tick();
      step_req = 1'b0;
      tick();
      tick();
      checks++;
      if (stage !== 3'(p + 2)) begin
        errors++;
        $display("FAIL step_press%0d stage=%0d expected %0d", p, stage, p + 2);
      end
      tick();
    end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    checks++;
    if (stage !== 3'd3 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL step_latency stage=%0d done=%b expected 3/0", stage, instr_done);
    end
    tick();
    checks++;
    if (stage !== 3'd0 || instr_done !== 1'b1 || instr_count !== 16'd1) begin
      errors++;
      $display("FAIL step_retire stage=%0d done=%b count=%0d expected 0/1/1",
               stage, instr_done, instr_count);
    end
  endtask

  task automatic test_async_reset();
    do_reset(1'b1);
    ir = 8'h3C;
    repeat (5) tick();
    checks++;
    if (stage !== 3'd0 || instr_count !== 16'd1) begin
      errors++;
      $display("FAIL sub_retire stage=%0d count=%0d expected 0/1", stage, instr_count);
    end
    repeat (3) tick();
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (stage !== 3'd0 || instr_count !== 16'd0 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL async_reset stage=%0d count=%0d done=%b expected 0/0/0",
               stage, instr_count, instr_done);
    end
    tick();
    rst_n = 1'b1;
    tick();
    checks++;
    if (stage !== 3'd1 || instr_done !== 1'b0 || instr_count !== 16'd0) begin
      errors++;
      $display("FAIL post_reset stage=%0d done=%b count=%0d expected 1/0/0",
               stage, instr_done, instr_count);
    end
  endtask

  task automatic test_mode_switch();
    do_reset(1'b1);
    ir = 8'h2A;
    tick();
    tick();
    run_mode = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      checks++;
      if (stage !== 3'd3) begin
        errors++;
        $display("FAIL mode_hold cyc%0d stage=%0d expected 3", i, stage);
      end
    end
    step_req = 1'b1;
    tick();
    step_req = 1'b0;
    tick();
    tick();
    checks++;
    if (stage !== 3'd4 || instr_done !== 1'b0) begin
      errors++;
      $display("FAIL mode_step stage=%0d done=%b expected 4/0", stage, instr_done);
    end
  endtask

  task automatic test_wrap();
    do_reset(1'b1);
    ir = 8'h00;
    for (int k = 1; k <= 80; k++) begin
      tick();
      if (k == 75) begin
        checks++;
        if (fx_count !== 4'hF) begin
          errors++;
          $display("FAIL wrap_pre got=%0d expected 15", fx_count);
        end
      end
    end
    checks++;
    if (fx_count !== 4'h0 || fx_done !== 1'b1) begin
      errors++;
      $display("FAIL wrap count=%0d done=%b expected 0/1", fx_count, fx_done);
    end
  endtask

  initial begin
    test_reset();
    test_run_add();
    test_ldi_lda();
    test_fixed();
    test_halt();
    test_step();
    test_async_reset();
    test_mode_switch();
    test_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/stage_sequencer.md
Name: stage_sequencer

Overview:
- Generates the 3-bit micro-step `stage` consumed by the control-signal decoder of the 8-bit CPU. Sits directly upstream of it.
- Shortens each instruction to its real length, freezes on halt, and supports free-run and single-step (debug button) modes.
- Reports instruction retirement and keeps a retired-instruction counter for the debug display.
- All state changes on the rising edge of `clk`. The control decoder samples `stage` on the falling edge, so `stage` is always stable when it is sampled.

Parameters:
- MAX_STAGE, 4, highest stage index any instruction uses. The `stage` port is 3 bits, so the legal range is 2..7.
- FIXED_LENGTH, 0, when 1 every instruction runs stages 0..MAX_STAGE (classic fixed-step mode). When 0, the per-opcode length applies.
- CNT_W, 16, width of `instr_count`.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- ir  input  8  instruction register; only [7:4] (opcode) is used.
- ctrl_ht  input  1  halt request from the control decoder.
- run_mode  input  1  1 = free run, 0 = single-step.
- step_req  input  1  asynchronous step button level, already debounced.
- resume  input  1  synchronous pulse; leaves the HALTED state.
- stage  output  3  current micro-step.
- halted  output  1  high while in the HALTED state.
- instr_done  output  1  one-cycle pulse when an instruction retires.
- instr_count  output  CNT_W  retired-instruction count; wraps modulo 2^CNT_W.

Behaviour:
- The interface has one clock; reset is asynchronous and active-low.
- Reset values:
  - stage = 0, halted = 0, instr_done = 0, instr_count = 0.
  - State = RUN if `run_mode` = 1, otherwise WAIT.
  - Step synchroniser flops = 0.
  - Reset mid-instruction abandons that instruction; it is not counted.
- Last stage per opcode, used when FIXED_LENGTH = 0:
  - 0001 LDA and 0100 STA: last stage 3.
  - 0010 ADD and 0011 SUB: last stage 4.
  - All others, including NOP, LDI, JMP, JC, JZ, OUT, HLT and the undefined opcodes 1001–1101: last stage 2.
- Stages 0 and 1 (fetch) ignore `ir`, because `ir` is only valid from stage 2 onward.
- Advance event, one per rising edge at most:
  - In RUN, every edge is an advance.
  - In WAIT, only the edge at which the synchronised step-edge pulse is high is an advance.
- On an advance:
  - If stage == last stage, stage goes to 0, `instr_done` pulses for 1 cycle, and `instr_count` increments.
  - Otherwise stage increments by 1.
- Step synchroniser:
  - Two flops (s1, s2) plus an edge register s3; pulse = s2 & ~s3.
  - If `step_req` is high at edge N, stage advances at edge N+2.
  - Exactly one advance per rising edge of `step_req`, regardless of how long it is held.
- State machine:
  - RUN → WAIT when `run_mode` = 0 is sampled. WAIT → RUN when `run_mode` = 1 is sampled. Stage is held across the switch; the instruction does not restart.
  - RUN or WAIT → HALTED when `ctrl_ht` = 1 at an edge. Stage freezes at its current value (2) and no advance occurs on that edge. `halted` = 1 from that edge.
  - HALTED → RUN or WAIT (selected by `run_mode`) when `resume` = 1 at an edge. Stage goes to 0 on that edge.
  - The HLT instruction is counted on resume: `instr_done` pulses and `instr_count` increments at that edge.
- Simultaneous events:
  - `ctrl_ht` outranks a step pulse or an advance in the same cycle.
  - `resume` outside HALTED is ignored.
  - `resume` and `ctrl_ht` both high while in HALTED: resume wins.
  - Step pulses arriving while in HALTED or RUN are discarded, not queued.
- `halted`, `stage`, `instr_done` and `instr_count` are all registered outputs; there are no combinational paths from inputs.

Test Plan:
1. Run mode, ir = 0x2A (ADD), FIXED_LENGTH = 0 → stage 0,1,2,3,4,0 on consecutive edges; `instr_done` high exactly one cycle on the 4→0 edge; `instr_count` goes 0→1.
2. Run mode, ir = 0x57 (LDI) then ir = 0x14 (LDA) → stage 0,1,2,0,1,2,3,0; `instr_count` = 2. Repeat with FIXED_LENGTH = 1 → both instructions run 0..4.
3. ir = 0xF0 (HLT), `ctrl_ht` driven high during stage 2 → stage frozen at 2 with `halted` = 1 for 20 cycles; `resume` pulse → stage = 0, `halted` = 0, `instr_count` +1.
4. `run_mode` = 0 with step_req held high for 10 cycles → exactly one advance, 2 edges after first sampled high. Three separate presses → stage 0→1→2→3 with ir = LDA.
5. Assert `rst_n` low asynchronously mid-stage 3 of SUB (ir = 0x3C) → stage = 0, `instr_count` = 0 immediately without a clock edge; `instr_done` never pulses.
6. Preload 0xFFFF retirements (CNT_W = 16) then retire one more → `instr_count` = 0x0000. `run_mode` toggled 1→0 at stage 3 of ADD → stage holds 3 until the next step press.
